// File: rtl/qerv_alu_pkg.sv
// qerv_alu_pkg: op codes, FSM states and sizing helpers shared by qerv_alu_seq.
// The MIN/MAX codes are always reserved here. They are decoded only when
// QERV_ALU_MINMAX_EN is defined.
package qerv_alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpXor  = 4'd2,
    OpOr   = 4'd3,
    OpAnd  = 4'd4,
    OpEq   = 4'd5,
    OpSlt  = 4'd6,
    OpSltu = 4'd7,
    OpMin  = 4'd8,
    OpMax  = 4'd9,
    OpMinu = 4'd10,
    OpMaxu = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StPass1,
    StPass2,
    StDone
  } alu_state_e;

  // Number of beats per operand word.
  function automatic int unsigned beats_f(int unsigned xlen, int unsigned w);
    return xlen / w;
  endfunction

  // Beat counter width; never narrower than one bit, even for a single-beat word.
  function automatic int unsigned cnt_width_f(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qerv_alu_seq_if.sv
// qerv_alu_seq_if: beat-stream and start/done handshake between the core control
// and the sequenced ALU.
interface qerv_alu_seq_if #(
  parameter int unsigned W = 4
) ();
  logic         i_start;
  logic [3:0]   i_op;
  logic         i_en;
  logic [W-1:0] i_rs1;
  logic [W-1:0] i_op_b;
  logic [W-1:0] o_rd;
  logic         o_rd_valid;
  logic         o_cmp;
  logic         o_busy;
  logic         o_done;

  modport master (
    output i_start, i_op, i_en, i_rs1, i_op_b,
    input  o_rd, o_rd_valid, o_cmp, o_busy, o_done
  );

  modport slave (
    input  i_start, i_op, i_en, i_rs1, i_op_b,
    output o_rd, o_rd_valid, o_cmp, o_busy, o_done
  );
endinterface

// File: rtl/qerv_alu_slice.sv
// qerv_alu_slice: W-bit combinational slice. It provides an adder/subtractor with
// carry in and out, the boolean ops, and an equality (zero) detect.
module qerv_alu_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic [W-1:0] xor_o,
  output logic [W-1:0] or_o,
  output logic [W-1:0] and_o,
  output logic         zero_o
);
  logic [W:0] total;

  // Subtraction uses the inverted operand. The caller seeds the carry with 1.
  always_comb begin
    total  = {1'b0, a_i} + {1'b0, b_i ^ {W{sub_i}}} + {{W{1'b0}}, cin_i};
    sum_o  = total[W-1:0];
    cout_o = total[W];
    xor_o  = a_i ^ b_i;
    or_o   = a_i | b_i;
    and_o  = a_i & b_i;
    zero_o = ~|(a_i ^ b_i);
  end
endmodule

// File: rtl/qerv_alu_seq.sv
// qerv_alu_seq: self-sequencing bit-slice ALU. It consumes XLEN/W beats per
// operand, LSB beat first. Compare ops (and MIN/MAX when QERV_ALU_MINMAX_EN is
// defined) run a second pass that streams the word-dependent result.
module qerv_alu_seq
  import qerv_alu_pkg::*;
#(
  parameter int unsigned W    = 4,
  parameter int unsigned XLEN = 32
) (
  input logic           clk,
  input logic           i_rst,
  qerv_alu_seq_if.slave bus
);
  localparam int unsigned N    = beats_f(XLEN, W);
  localparam int unsigned CntW = cnt_width_f(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  alu_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic          cy_q, cy_d;
  logic          eq_q, eq_d;
  logic          cmp_q, cmp_d;

  logic [W-1:0]  slice_sum, slice_xor, slice_or, slice_and, slice_res;
  logic          slice_cout, slice_zero;
  logic          last_beat, lt_now;
  logic [W-1:0]  pass2_beat, rd;
  logic          rd_valid;

  function automatic logic is_signed_lt(logic [3:0] op);
`ifdef QERV_ALU_MINMAX_EN
    return (op == OpSlt) || (op == OpMin) || (op == OpMax);
`else
    return op == OpSlt;
`endif
  endfunction

  function automatic logic is_unsigned_lt(logic [3:0] op);
`ifdef QERV_ALU_MINMAX_EN
    return (op == OpSltu) || (op == OpMinu) || (op == OpMaxu);
`else
    return op == OpSltu;
`endif
  endfunction

  function automatic logic is_lt_op(logic [3:0] op);
    return is_signed_lt(op) || is_unsigned_lt(op);
  endfunction

  function automatic logic is_single_out(logic [3:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpXor) || (op == OpOr) || (op == OpAnd);
  endfunction

  qerv_alu_slice #(
    .W(W)
  ) u_slice (
    .a_i   (bus.i_rs1),
    .b_i   (bus.i_op_b),
    .cin_i (cy_q),
    .sub_i (op_q == OpSub || is_lt_op(op_q)),
    .sum_o (slice_sum),
    .cout_o(slice_cout),
    .xor_o (slice_xor),
    .or_o  (slice_or),
    .and_o (slice_and),
    .zero_o(slice_zero)
  );

  assign last_beat = (cnt_q == LastCnt);

  // Select the single-pass result beat and form the whole-word less-than on the top beat.
  always_comb begin
    slice_res = slice_sum;
    case (op_q)
      OpXor:   slice_res = slice_xor;
      OpOr:    slice_res = slice_or;
      OpAnd:   slice_res = slice_and;
      default: slice_res = slice_sum;
    endcase
    // Bit XLEN of the sign-extended difference: rs1_msb + ~opb_msb + carry-out.
    if (is_signed_lt(op_q)) begin
      lt_now = bus.i_rs1[W-1] ^ ~bus.i_op_b[W-1] ^ slice_cout;
    end else begin
      lt_now = ~slice_cout;
    end
  end

`ifdef QERV_ALU_MINMAX_EN
  logic [XLEN-1:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d;
  logic            pick_a;

  // MIN takes rs1 when lt. MAX takes rs1 when not lt.
  assign pick_a = cmp_q ^ ((op_q == OpMax) || (op_q == OpMaxu));

  // Capture operands LSB-first in PASS1. Stream them out LSB-first in PASS2.
  always_comb begin
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    if (bus.i_en && state_q == StPass1) begin
      buf_a_d = {bus.i_rs1, buf_a_q[XLEN-1:W]};
      buf_b_d = {bus.i_op_b, buf_b_q[XLEN-1:W]};
    end else if (bus.i_en && state_q == StPass2) begin
      buf_a_d = buf_a_q >> W;
      buf_b_d = buf_b_q >> W;
    end
  end

  // Operand buffer registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else begin
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
    end
  end
`endif

  // PASS2 beat: the set-less-than word is {0..., lt}. MIN/MAX stream the selected buffer.
  always_comb begin
    pass2_beat = (cnt_q == '0) ? W'(cmp_q) : '0;
`ifdef QERV_ALU_MINMAX_EN
    if (is_lt_op(op_q) && op_q != OpSlt && op_q != OpSltu) begin
      pass2_beat = pick_a ? buf_a_q[W-1:0] : buf_b_q[W-1:0];
    end
`endif
  end

  // Sequencer next state and result beat.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    cy_d     = cy_q;
    eq_d     = eq_q;
    cmp_d    = cmp_q;
    rd_valid = 1'b0;
    rd       = '0;
    unique case (state_q)
      StIdle: begin
        // i_en in the start cycle is ignored. Beat 0 arrives on a later cycle.
        if (bus.i_start) begin
          state_d = StPass1;
          op_d    = bus.i_op;
          cnt_d   = '0;
          cy_d    = (bus.i_op == OpSub) || is_lt_op(bus.i_op) || (bus.i_op == OpEq);
          eq_d    = 1'b1;
        end
      end
      StPass1: begin
        if (bus.i_en) begin
          cnt_d = last_beat ? '0 : cnt_q + CntW'(1);
          cy_d  = slice_cout;
          eq_d  = eq_q & slice_zero;
          if (is_single_out(op_q)) begin
            rd_valid = 1'b1;
            rd       = slice_res;
          end
          if (last_beat) begin
            if (op_q == OpEq) begin
              cmp_d = eq_q & slice_zero;
            end else if (is_lt_op(op_q)) begin
              cmp_d = lt_now;
            end else begin
              cmp_d = 1'b0;
            end
            state_d = is_lt_op(op_q) ? StPass2 : StDone;
          end
        end
      end
      StPass2: begin
        if (bus.i_en) begin
          cnt_d    = last_beat ? '0 : cnt_q + CntW'(1);
          rd_valid = 1'b1;
          rd       = pass2_beat;
          if (last_beat) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 4'(OpAdd);
      cy_q    <= 1'b0;
      eq_q    <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      cy_q    <= cy_d;
      eq_q    <= eq_d;
      cmp_q   <= cmp_d;
    end
  end

  // Suppress result beats in the reset cycle so an abort never writes rd.
  always_comb begin
    bus.o_rd_valid = rd_valid & ~i_rst;
    bus.o_rd       = bus.o_rd_valid ? rd : '0;
    bus.o_cmp      = cmp_q;
    bus.o_busy     = (state_q != StIdle);
    bus.o_done     = (state_q == StDone);
  end
endmodule

// File: tb/tb_qerv_alu_seq.sv
// tb_qerv_alu_seq: scoreboard bench for qerv_alu_seq (W=4, XLEN=32). The bench
// pushes expected rd beats when it issues an op and pops them as o_rd_valid beats
// appear. Define QERV_ALU_MINMAX_EN to match an RTL build that has MIN/MAX.
module tb_qerv_alu_seq;
  import qerv_alu_pkg::*;

  localparam int unsigned W    = 4;
  localparam int unsigned XLEN = 32;
  localparam int unsigned N    = XLEN / W;

  logic clk = 1'b0;
  logic rst;

  qerv_alu_seq_if #(.W(W)) bus ();

  qerv_alu_seq #(
    .W   (W),
    .XLEN(XLEN)
  ) dut (
    .clk  (clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  logic [W-1:0] exp_q[$];
  logic exp_cmp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one operation.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic has_rd,
                                output logic cmp, output logic two);
    res = '0; has_rd = 1'b0; cmp = 1'b0; two = 1'b0;
    case (op)
      OpAdd: begin res = a + b; has_rd = 1'b1; end
      OpSub: begin res = a - b; has_rd = 1'b1; end
      OpXor: begin res = a ^ b; has_rd = 1'b1; end
      OpOr:  begin res = a | b; has_rd = 1'b1; end
      OpAnd: begin res = a & b; has_rd = 1'b1; end
      OpEq:  cmp = (a == b);
      OpSlt: begin
        cmp = ($signed(a) < $signed(b)); res = {31'b0, cmp}; has_rd = 1'b1; two = 1'b1;
      end
      OpSltu: begin
        cmp = (a < b); res = {31'b0, cmp}; has_rd = 1'b1; two = 1'b1;
      end
`ifdef QERV_ALU_MINMAX_EN
      OpMin:  begin cmp = ($signed(a) < $signed(b)); res = cmp ? a : b; has_rd = 1'b1; two = 1'b1; end
      OpMax:  begin cmp = ($signed(a) < $signed(b)); res = cmp ? b : a; has_rd = 1'b1; two = 1'b1; end
      OpMinu: begin cmp = (a < b); res = cmp ? a : b; has_rd = 1'b1; two = 1'b1; end
      OpMaxu: begin cmp = (a < b); res = cmp ? b : a; has_rd = 1'b1; two = 1'b1; end
`endif
      default: ;
    endcase
  endfunction

  // Scoreboard: compare every produced beat and require o_rd==0 when it is not valid.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.o_done === 1'b1) n_done++;
    if (bus.o_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rd", 32'(bus.o_rd), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("rd_beat", 32'(bus.o_rd), 32'(e));
      end
    end else begin
      check_eq("rd_zero_idle", 32'(bus.o_rd), 32'h0);
    end
  end

  // Issue one op. i_start stays high while busy to show that it is ignored. i_en is
  // high in the start cycle to show that it is ignored there too.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int gap);
    logic [31:0] res;
    logic has_rd, cmp, two;
    int done0;
    model(op, a, b, res, has_rd, cmp, two);
    if (has_rd) for (int i = 0; i < N; i++) exp_q.push_back(res[i*W +: W]);
    done0 = n_done;
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_op = op; bus.i_en = 1'b1;
    bus.i_rs1 = W'($urandom); bus.i_op_b = W'($urandom);
    for (int p = 0; p < (two ? 2 : 1); p++) begin
      for (int i = 0; i < N; i++) begin
        @(posedge clk); #1;
        if (p == 0 && i == 0) begin
          check_eq({tag, ".busy"}, 32'(bus.o_busy), 32'h1);
          check_eq({tag, ".cmp_hold"}, 32'(bus.o_cmp), 32'(exp_cmp));
        end
        bus.i_op   = ~op;
        bus.i_en   = 1'b1;
        bus.i_rs1  = (p == 0) ? a[i*W +: W] : W'($urandom);
        bus.i_op_b = (p == 0) ? b[i*W +: W] : W'($urandom);
        if (i != N - 1) begin
          repeat (gap) begin
            @(posedge clk); #1;
            bus.i_en = 1'b0; bus.i_rs1 = W'($urandom); bus.i_op_b = W'($urandom);
          end
        end
      end
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_en = 1'b0;
    check_eq({tag, ".done"}, 32'(bus.o_done), 32'h1);
    check_eq({tag, ".busy_done"}, 32'(bus.o_busy), 32'h1);
    @(posedge clk); #1;
    check_eq({tag, ".done_low"}, 32'(bus.o_done), 32'h0);
    check_eq({tag, ".busy_low"}, 32'(bus.o_busy), 32'h0);
    check_eq({tag, ".cmp"}, 32'(bus.o_cmp), 32'(cmp));
    check_eq({tag, ".done_pulses"}, 32'(n_done - done0), 32'h1);
    check_eq({tag, ".beats_left"}, 32'(exp_q.size()), 32'h0);
    exp_cmp = cmp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic [3:0] op;
    int done0;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_op = '0; bus.i_en = 1'b0; bus.i_rs1 = '0; bus.i_op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.busy", 32'(bus.o_busy), 32'h0);
    check_eq("reset.done", 32'(bus.o_done), 32'h0);
    check_eq("reset.cmp", 32'(bus.o_cmp), 32'h0);
    check_eq("reset.rd_valid", 32'(bus.o_rd_valid), 32'h0);
    rst = 1'b0;

    run_op("add_ovf", OpAdd, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op("sub_stall", OpSub, 32'h5, 32'h7, 2);
    run_op("slt", OpSlt, 32'h8000_0000, 32'h0000_0001, 0);
    run_op("sltu", OpSltu, 32'h8000_0000, 32'h0000_0001, 1);
    run_op("eq_same", OpEq, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    run_op("eq_diff", OpEq, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 0);

    // Abort a SUB at PASS1 beat 3. Only beats 0..2 may reach rd.
    a = 32'h1234_5678; b = 32'h0000_0001;
    for (int i = 0; i < 3; i++) exp_q.push_back(W'((a - b) >> (i * W)));
    done0 = n_done;
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_op = OpSub;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.i_start = 1'b0; bus.i_en = 1'b1;
      bus.i_rs1 = a[i*W +: W]; bus.i_op_b = b[i*W +: W];
      if (i == 3) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.i_en = 1'b0;
    check_eq("abort.busy", 32'(bus.o_busy), 32'h0);
    check_eq("abort.cmp", 32'(bus.o_cmp), 32'h0);
    check_eq("abort.beats_left", 32'(exp_q.size()), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort.no_done", 32'(n_done - done0), 32'h0);
    exp_cmp = 1'b0;
    run_op("add_after_abort", OpAdd, 32'h1, 32'h1, 0);

    run_op("xor", OpXor, 32'hA5A5_0F0F, 32'h5A5A_FF00, 1);
    run_op("or", OpOr, 32'h1200_0034, 32'h0056_7800, 0);
    run_op("and", OpAnd, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 0);
    run_op("slt_neg", OpSlt, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    run_op("illegal", 4'hF, 32'h1234, 32'h5678, 0);
    run_op("min", OpMin, 32'hFFFF_FFFD, 32'h2, 0);
    run_op("minu", OpMinu, 32'hFFFF_FFFD, 32'h2, 1);
    run_op("max", OpMax, 32'hFFFF_FFFD, 32'h2, 0);
    run_op("maxu", OpMaxu, 32'hFFFF_FFFD, 32'h2, 0);

    for (int k = 0; k < 6; k++) begin
      op = 4'($urandom_range(0, 7));
      a  = $urandom;
      b  = (k == 2) ? a : $urandom;
      run_op("random", op, a, b, int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
